key_debounce: RTL
=================

# key_debounce

Multi-channel push-button input conditioner for the PL fabric, the input-side counterpart to the board LED drivers. Each raw, bouncing, active-low key pin is synchronised to `CLK`, debounced with a time-based counter and turned into a clean level plus single-cycle press, release and long-press event pulses. These pulses are what downstream LED-pattern and mode-select logic consumes.

## Interface
Parameters:
- `CLOCK_FREQ`, 50000000: `CLK` frequency in Hz.
- `DEBOUNCE_MS`, 20: stable time required before a press or release is accepted.
- `LONG_PRESS_MS`, 1000: held time, measured from the accepted press, that raises a long-press event.
- `NUM_KEYS`, 4: number of independent key channels.

Ports:
- `CLK` in 1: PL clock.
- `RST_N` in 1: reset. One clock; reset is asynchronous and active-low.
- `KEY_N` in `NUM_KEYS`: raw key pins, 0 = pressed, asynchronous to `CLK`.
- `KEY_LEVEL` out `NUM_KEYS`: debounced state, 1 = pressed.
- `KEY_PRESS` out `NUM_KEYS`: one-cycle pulse on each accepted press.
- `KEY_RELEASE` out `NUM_KEYS`: one-cycle pulse on each accepted release.
- `KEY_LONG` out `NUM_KEYS`: one-cycle pulse, at most once per press, when the hold time reaches `LONG_PRESS_MS`.

## Operation
- Derived constants: `DEB_MAX = CLOCK_FREQ/1000*DEBOUNCE_MS - 1` and `LONG_MAX = CLOCK_FREQ/1000*LONG_PRESS_MS - 1`. Both are 32-bit unsigned. `DEB_MAX >= 1` is required, and elaboration fails otherwise.
- Each channel has a 2-flop synchroniser whose reset value is 1 (released). Its output `k` is 1 when the key is pressed.
- Each channel has an independent state machine with states IDLE, PRESS_WAIT, PRESSED, LONG_HELD and RELEASE_WAIT, plus a debounce counter `dcnt` and a long counter `lcnt`.
- IDLE: if `k` then go to PRESS_WAIT with `dcnt=0`.
- PRESS_WAIT: if `!k` then go to IDLE with no event. Else if `dcnt==DEB_MAX` then go to PRESSED with `lcnt=0` and pulse `KEY_PRESS`. Else `dcnt++`.
- PRESSED: if `!k` then go to RELEASE_WAIT with `dcnt=0`. Else if `lcnt==LONG_MAX` then go to LONG_HELD and pulse `KEY_LONG`. Else `lcnt++`.
- LONG_HELD: if `!k` then go to RELEASE_WAIT with `dcnt=0`. Otherwise hold, with no further `KEY_LONG`.
- RELEASE_WAIT:
  - If `k`, return to the state it was entered from. A `was_long` flag records that state. `dcnt` is cleared, `lcnt` is frozen and not reset, and no event is raised.
  - Else if `dcnt==DEB_MAX`, go to IDLE and pulse `KEY_RELEASE`.
  - Else `dcnt++`.
- `KEY_LEVEL` is 1 in PRESSED, LONG_HELD and RELEASE_WAIT, and 0 otherwise.
- Channels never interact. Simultaneous events on different keys are all reported in the same cycle.

## Timing
- All outputs are registered. Reset value of every output is 0, and every state machine resets to IDLE with counters at 0.
- Press latency: `KEY_N` is first sampled low at edge 0 and held low. `KEY_PRESS` is high for exactly the cycle after edge `DEB_MAX+3`, and `KEY_LEVEL` rises at the same edge.
- Release latency is symmetric: `KEY_RELEASE` is high after edge `DEB_MAX+3`, counted from the first edge sampling `KEY_N` high. `KEY_LEVEL` falls at the same edge.
- `KEY_LONG` rises at the edge `LONG_MAX+1` cycles after the edge that raised `KEY_PRESS`, provided no bounce occurs. Time spent in RELEASE_WAIT extends this by the frozen cycles.
- Glitches shorter than `DEB_MAX+1` synchronised cycles produce no event.
- The `KEY_PRESS`, `KEY_LONG` and `KEY_RELEASE` pulses of one channel are never coincident.
- An `RST_N` assertion mid-press clears everything immediately. After release of reset, a key still held is treated as a new press and must debounce again.

## Structure
- Package `key_pkg` holds:
  - the channel state enum;
  - the function `ms_to_cycles(freq, ms)`;
  - the synchroniser reset constant `KEY_IDLE_LEVEL = 1'b1`.
- Sub-module `key_debounce_channel` contains one synchroniser, the state machine and both counters. The top level generates `NUM_KEYS` instances and concatenates their outputs.

## Test plan
All scenarios use `CLOCK_FREQ=1000`, `DEBOUNCE_MS=4` and `LONG_PRESS_MS=10`, giving `DEB_MAX=3` and `LONG_MAX=9`.
- Reset: hold `RST_N` low with `KEY_N=4'b0000` -> all outputs are 0. After release, `KEY_PRESS=4'b1111` appears 6 cycles later.
- Clean press: `KEY_N[0]` goes low and is held -> `KEY_PRESS[0]` is a single pulse after edge 6 and `KEY_LEVEL[0]=1`. `KEY_LONG[0]` pulses 10 cycles after `KEY_PRESS`, once only.
- Bounce: toggle `KEY_N[1]` low for 3 cycles, high for 1, then low and held -> no event during the bounce. `KEY_PRESS[1]` comes 6 cycles after the final fall.
- Release glitch: press `KEY_N[2]` to PRESSED, then a 2-cycle high glitch -> no `KEY_RELEASE`, `KEY_LEVEL` stays 1. A sustained high then gives `KEY_RELEASE[2]` after 6 cycles.
- Simultaneous keys: `KEY_N[3]` and `KEY_N[0]` fall on the same edge -> `KEY_PRESS=4'b1001` in a single cycle.
- Reset mid-hold: assert `RST_N` while `KEY_LEVEL[0]=1`, before `KEY_LONG` -> all outputs clear asynchronously. No `KEY_RELEASE` is emitted, and the held key re-presses 6 cycles after reset release.

Source files
------------

// File: rtl/key_pkg.sv
// Shared types and elaboration helpers for the key_debounce input conditioner.
// Holds the channel state encoding, the ms-to-cycles conversion and the synchroniser idle level.
package key_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRESS_WAIT,
    ST_PRESSED,
    ST_LONG_HELD,
    ST_RELEASE_WAIT
  } key_state_e;

  // A released key pin reads high, so the synchroniser comes out of reset "released".
  localparam logic KEY_IDLE_LEVEL = 1'b1;

  function automatic logic [31:0] ms_to_cycles(input logic [31:0] freq, input logic [31:0] ms);
    return (freq / 32'd1000) * ms;
  endfunction

  // Smallest counter width able to hold the value v (at least 1 bit).
  function automatic int width_for(input logic [31:0] v);
    int w;
    w = 1;
    for (int i = 1; i < 32; i++) begin
      if ((v >> i) != 32'd0) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/key_debounce_channel.sv
// One key channel: 2-flop synchroniser, debounce/long-press state machine and its counters.
// All outputs are registered; event pulses last exactly one clock.
module key_debounce_channel
  import key_pkg::*;
#(
  parameter logic [31:0] DEB_MAX  = 32'd1,
  parameter logic [31:0] LONG_MAX = 32'd1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_key_n,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_long
);

  localparam int DW = width_for(DEB_MAX);
  localparam int LW = width_for(LONG_MAX);
  localparam logic [DW-1:0] DEB_END  = DEB_MAX[DW-1:0];
  localparam logic [LW-1:0] LONG_END = LONG_MAX[LW-1:0];

  logic [1:0]    r_sync;
  key_state_e    r_state;
  logic [DW-1:0] r_dcnt;
  logic [LW-1:0] r_lcnt;
  logic          r_was_long;
  logic          w_k;

  // r_sync[1] is the metastability-hardened copy of the raw pin.
  assign w_k = ~r_sync[1];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= {2{KEY_IDLE_LEVEL}};
    end else begin
      // NOTE: non-blocking so the second flop captures the first flop's previous value.
      r_sync <= {r_sync[0], i_key_n};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_dcnt     <= '0;
      r_lcnt     <= '0;
      r_was_long <= 1'b0;
      o_level    <= 1'b0;
      o_press    <= 1'b0;
      o_release  <= 1'b0;
      o_long     <= 1'b0;
    end else begin
      o_press   <= 1'b0;
      o_release <= 1'b0;
      o_long    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_k) begin
            r_state <= ST_PRESS_WAIT;
            r_dcnt  <= '0;
          end
        end
        ST_PRESS_WAIT: begin
          if (!w_k) begin
            r_state <= ST_IDLE;
          end else if (r_dcnt == DEB_END) begin
            r_state <= ST_PRESSED;
            r_lcnt  <= '0;
            o_press <= 1'b1;
            o_level <= 1'b1;
          end else begin
            r_dcnt <= r_dcnt + DW'(1);
          end
        end
        ST_PRESSED: begin
          if (!w_k) begin
            r_state    <= ST_RELEASE_WAIT;
            r_dcnt     <= '0;
            r_was_long <= 1'b0;
          end else if (r_lcnt == LONG_END) begin
            r_state <= ST_LONG_HELD;
            o_long  <= 1'b1;
          end else begin
            r_lcnt <= r_lcnt + LW'(1);
          end
        end
        ST_LONG_HELD: begin
          if (!w_k) begin
            r_state    <= ST_RELEASE_WAIT;
            r_dcnt     <= '0;
            r_was_long <= 1'b1;
          end
        end
        ST_RELEASE_WAIT: begin
          // A bounce during release resumes the hold; r_lcnt stays frozen meanwhile.
          if (w_k) begin
            r_state <= r_was_long ? ST_LONG_HELD : ST_PRESSED;
            r_dcnt  <= '0;
          end else if (r_dcnt == DEB_END) begin
            r_state   <= ST_IDLE;
            o_release <= 1'b1;
            o_level   <= 1'b0;
          end else begin
            r_dcnt <= r_dcnt + DW'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/key_debounce.sv
// Multi-channel push-button conditioner: NUM_KEYS independent debounce channels side by side.
// Raw active-low pins in; clean level plus press, release and long-press pulses out.
module key_debounce
  import key_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ    = 50000000,
  parameter int unsigned DEBOUNCE_MS   = 20,
  parameter int unsigned LONG_PRESS_MS = 1000,
  parameter int unsigned NUM_KEYS      = 4
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic [NUM_KEYS-1:0] KEY_N,
  output logic [NUM_KEYS-1:0] KEY_LEVEL,
  output logic [NUM_KEYS-1:0] KEY_PRESS,
  output logic [NUM_KEYS-1:0] KEY_RELEASE,
  output logic [NUM_KEYS-1:0] KEY_LONG
);

  localparam logic [31:0] DEB_CYCLES  = ms_to_cycles(CLOCK_FREQ, DEBOUNCE_MS);
  localparam logic [31:0] LONG_CYCLES = ms_to_cycles(CLOCK_FREQ, LONG_PRESS_MS);
  localparam logic [31:0] DEB_MAX     = DEB_CYCLES - 32'd1;
  localparam logic [31:0] LONG_MAX    = LONG_CYCLES - 32'd1;

  // A zero-length debounce window would let single-cycle glitches through.
  if (DEB_CYCLES < 32'd2) begin : g_bad_debounce
    $error("key_debounce: DEB_MAX must be at least 1");
  end

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    key_debounce_channel #(
      .DEB_MAX  (DEB_MAX),
      .LONG_MAX (LONG_MAX)
    ) u_channel (
      .i_clk     (CLK),
      .i_rst_n   (RST_N),
      .i_key_n   (KEY_N[g]),
      .o_level   (KEY_LEVEL[g]),
      .o_press   (KEY_PRESS[g]),
      .o_release (KEY_RELEASE[g]),
      .o_long    (KEY_LONG[g])
    );
  end

endmodule
